// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
//   Shared constants and types for the digit-classifier front end.
//   IMG_W/IMG_H : image size in pixels
//   K           : window edge
//   PW          : pixel width in bits
//   WIN_W       : flattened window width (K*K*PW)
//   CW          : width of the row/column counters and of X/Y
//   state_t     : window_feeder FSM encoding
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 5;
    localparam int PW    = 8;
    localparam int WIN_W = K * K * PW;
    localparam int CW    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STREAM = 2'b01,
        ST_ISSUE  = 2'b10,
        ST_WAIT   = 2'b11
    } state_t;

endpackage

// File: rtl/window_linebuf.sv
// ---------------------------------------------------------------------------
// window_linebuf
//   Circular K-row line buffer with one write port and a combinational
//   K x K window read.
//   CLK             : clock, rising edge
//   wr_en           : write PIX data this edge
//   wr_slot/wr_col  : slot (row mod K) and column of the write
//   wr_data         : pixel to store
//   rd_slot         : slot holding the window's top row
//   rd_col          : window's left column
//   rd_win          : flattened window, pixel (i,j) at [(i*K+j)*PW +: PW]
// ---------------------------------------------------------------------------
module window_linebuf #(
    parameter int IMG_W = cnn_pkg::IMG_W,
    parameter int K     = cnn_pkg::K,
    parameter int PW    = cnn_pkg::PW
) (
    input  logic                         CLK,
    input  logic                         wr_en,
    input  logic [$clog2(K)-1:0]         wr_slot,
    input  logic [cnn_pkg::CW-1:0]       wr_col,
    input  logic [PW-1:0]                wr_data,
    input  logic [$clog2(K)-1:0]         rd_slot,
    input  logic [cnn_pkg::CW-1:0]       rd_col,
    output logic [K*K*PW-1:0]            rd_win
);
    import cnn_pkg::*;

    localparam int SW  = $clog2(K);
    localparam int SW1 = SW + 1;

    // Contents are never reset; a row is always rewritten before any
    // window reads it.
    logic [PW-1:0] mem [K][IMG_W];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_slot][wr_col] <= wr_data;
        end
    end

    // Window row i lives in slot (rd_slot + i) mod K.
    for (genvar i = 0; i < K; i++) begin : g_row
        logic [SW:0]   slot_sum;
        logic [SW-1:0] slot;

        assign slot_sum = {1'b0, rd_slot} + SW1'(i);
        assign slot     = (slot_sum >= SW1'(K)) ? SW'(slot_sum - SW1'(K))
                                                : slot_sum[SW-1:0];

        for (genvar j = 0; j < K; j++) begin : g_col
            assign rd_win[(i*K+j)*PW +: PW] = mem[slot][rd_col + CW'(j)];
        end
    end

endmodule

// File: rtl/window_feeder.sv
// ---------------------------------------------------------------------------
// window_feeder
//   Raster-to-window front end. Accepts one pixel per handshake into a
//   circular K-row line buffer and, whenever a pixel completes a K x K
//   window, presents that window and its top-left coordinate to the
//   downstream stage, stalling the pixel stream until DONE.
//   CLK        : clock, rising edge
//   nRST       : asynchronous active-low reset
//   PIX_VALID  : PIX_IN holds a valid pixel
//   PIX_IN     : pixel data, raster order
//   PIX_READY  : pixel accepted on an edge with PIX_VALID && PIX_READY
//   START      : one-cycle pulse, X/Y/IMGIN valid
//   X, Y       : window top-left column/row
//   IMGIN      : flattened window, pixel (i,j) at [(i*K+j)*PW +: PW]
//   DONE       : downstream finished current window (sampled in WAIT only)
//   FRAME_END  : one-cycle pulse after the last window is acknowledged
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | one cycle between frames, no pixels accepted
//   ST_STREAM | accepting pixels into the line buffer
//   ST_ISSUE  | START pulse, window registers freshly loaded
//   ST_WAIT   | window held, stream stalled until DONE
// ---------------------------------------------------------------------------
module window_feeder #(
    parameter int IMG_W = cnn_pkg::IMG_W,
    parameter int IMG_H = cnn_pkg::IMG_H,
    parameter int K     = cnn_pkg::K,
    parameter int PW    = cnn_pkg::PW
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 PIX_VALID,
    input  logic [PW-1:0]        PIX_IN,
    output logic                 PIX_READY,
    output logic                 START,
    output logic [4:0]           X,
    output logic [4:0]           Y,
    output logic [K*K*PW-1:0]    IMGIN,
    input  logic                 DONE,
    output logic                 FRAME_END
);
    import cnn_pkg::*;

    localparam int SW = $clog2(K);

    state_t              state_q, state_d;
    logic [CW-1:0]       row_q, col_q;
    logic [SW-1:0]       slot_q;
    logic [CW-1:0]       x_q, y_q;
    logic [K*K*PW-1:0]   win_q;
    logic                fe_q;

    logic                accept, win_hit, last_win, frame_done;
    logic [SW-1:0]       top_slot;
    logic [CW-1:0]       top_col;
    logic [K*K*PW-1:0]   rd_win;

    assign accept     = PIX_VALID && (state_q == ST_STREAM);
    assign win_hit    = accept && (row_q >= CW'(K-1)) && (col_q >= CW'(K-1));
    assign last_win   = (x_q == CW'(IMG_W-K)) && (y_q == CW'(IMG_H-K));
    assign frame_done = (state_q == ST_WAIT) && DONE && last_win;

    // Top row of the window is row-(K-1), whose slot is (row+1) mod K.
    assign top_slot = (slot_q == SW'(K-1)) ? '0 : slot_q + SW'(1);
    assign top_col  = col_q - CW'(K-1);

    window_linebuf #(
        .IMG_W (IMG_W),
        .K     (K),
        .PW    (PW)
    ) u_linebuf (
        .CLK     (CLK),
        .wr_en   (accept),
        .wr_slot (slot_q),
        .wr_col  (col_q),
        .wr_data (PIX_IN),
        .rd_slot (top_slot),
        .rd_col  (top_col),
        .rd_win  (rd_win)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   state_d = ST_STREAM;
            ST_STREAM: if (win_hit) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT:   if (DONE) state_d = last_win ? ST_IDLE : ST_STREAM;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        PIX_READY = (state_q == ST_STREAM);
        START     = (state_q == ST_ISSUE);
    end

    // Row wraps at the last pixel so counters stay within the image.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            row_q  <= '0;
            col_q  <= '0;
            slot_q <= '0;
        end else if (frame_done) begin
            row_q  <= '0;
            col_q  <= '0;
            slot_q <= '0;
        end else if (accept) begin
            if (col_q == CW'(IMG_W-1)) begin
                col_q <= '0;
                if (row_q == CW'(IMG_H-1)) begin
                    row_q  <= '0;
                    slot_q <= '0;
                end else begin
                    row_q  <= row_q + CW'(1);
                    slot_q <= (slot_q == SW'(K-1)) ? '0 : slot_q + SW'(1);
                end
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // The completing pixel is written on the same edge, so it is bypassed
    // straight into the bottom-right position of the captured window.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            x_q   <= '0;
            y_q   <= '0;
            win_q <= '0;
            fe_q  <= 1'b0;
        end else begin
            fe_q <= frame_done;
            if (win_hit) begin
                x_q   <= top_col;
                y_q   <= row_q - CW'(K-1);
                win_q <= {PIX_IN, rd_win[K*K*PW-PW-1:0]};
            end
        end
    end

    assign X         = x_q;
    assign Y         = y_q;
    assign IMGIN     = win_q;
    assign FRAME_END = fe_q;

endmodule

// File: tb/tb_window_feeder.sv
module tb_window_feeder;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         PIX_VALID;
    logic [7:0]   PIX_IN;
    logic         PIX_READY;
    logic         START;
    logic [4:0]   X;
    logic [4:0]   Y;
    logic [199:0] IMGIN;
    logic         DONE;
    logic         FRAME_END;

    int n_vec = 0;
    int n_err = 0;

    int tr = 0;
    int tc = 0;
    bit auto_done = 1'b0;
    bit start_prev = 1'b0;

    int mon_starts = 0;
    int mon_order_err = 0;
    int mon_win_err = 0;
    int mon_fe = 0;
    int mon_exp_x = 0;
    int mon_exp_y = 0;
    logic [4:0] mon_last_x = '0;
    logic [4:0] mon_last_y = '0;

    window_feeder dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .PIX_VALID (PIX_VALID),
        .PIX_IN    (PIX_IN),
        .PIX_READY (PIX_READY),
        .START     (START),
        .X         (X),
        .Y         (Y),
        .IMGIN     (IMGIN),
        .DONE      (DONE),
        .FRAME_END (FRAME_END)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r * 28 + c);
    endfunction

    function automatic logic [199:0] win_of(input int x, input int y);
        logic [199:0] w;
        w = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[(i*5+j)*8 +: 8] = pix(y + i, x + j);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        if (auto_done) DONE = start_prev;
        start_prev = START;
    endtask

    task automatic push(input bit gaps);
        int w;
        PIX_VALID = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        PIX_VALID = 1'b1;
        PIX_IN = pix(tr, tc);
        w = 0;
        while (!PIX_READY && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) chk("ready_timeout", 1'b0, 1'b1);
        tick();
        PIX_VALID = 1'b0;
        if (tc == 27) begin
            tc = 0;
            tr = (tr == 27) ? 0 : tr + 1;
        end else begin
            tc++;
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ready"}, PIX_READY, 1'b0);
        chk({pfx, "_start"}, START, 1'b0);
        chk({pfx, "_x"}, X, 5'd0);
        chk({pfx, "_y"}, Y, 5'd0);
        chk({pfx, "_imgin"}, IMGIN, 200'd0);
        chk({pfx, "_fe"}, FRAME_END, 1'b0);
    endtask

    always @(posedge CLK) begin
        #1;
        if (!nRST) begin
            mon_exp_x = 0;
            mon_exp_y = 0;
        end else begin
            if (START) begin
                mon_starts++;
                mon_last_x = X;
                mon_last_y = Y;
                if (int'(X) != mon_exp_x || int'(Y) != mon_exp_y) mon_order_err++;
                if (IMGIN !== win_of(int'(X), int'(Y))) mon_win_err++;
                if (mon_exp_x == 23) begin
                    mon_exp_x = 0;
                    mon_exp_y = (mon_exp_y == 23) ? 0 : mon_exp_y + 1;
                end else begin
                    mon_exp_x++;
                end
            end
            if (FRAME_END) mon_fe++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base;
        bit bp_ready;

        nRST = 1'b0;
        PIX_VALID = 1'b0;
        PIX_IN = '0;
        DONE = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("rst");

        nRST = 1'b1;
        chk("idle_ready", PIX_READY, 1'b0);
        tick();
        chk("ready_after_idle", PIX_READY, 1'b1);

        // first window
        repeat (116) push(1'b0);
        chk("no_early_start", mon_starts, 0);
        push(1'b0);
        chk("first_start", START, 1'b1);
        chk("first_x", X, 5'd0);
        chk("first_y", Y, 5'd0);
        chk("first_px00", IMGIN[7:0], 8'd0);
        chk("first_px44", IMGIN[199:192], 8'd116);
        chk("first_ready", PIX_READY, 1'b0);

        // backpressure with the next pixel held valid through WAIT
        PIX_VALID = 1'b1;
        PIX_IN = pix(tr, tc);
        bp_ready = 1'b0;
        repeat (10) begin
            tick();
            if (PIX_READY) bp_ready = 1'b1;
        end
        chk("bp_ready", bp_ready, 1'b0);
        chk("bp_starts", mon_starts, 1);
        chk("bp_xy", {X, Y}, 10'd0);
        chk("bp_win", IMGIN, win_of(0, 0));
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        chk("done_ready", PIX_READY, 1'b1);
        push(1'b0);
        chk("second_start", START, 1'b1);
        chk("second_x", X, 5'd1);
        chk("second_y", Y, 5'd0);

        // rest of frame 1 with random gaps and auto DONE
        auto_done = 1'b1;
        while (!(tr == 0 && tc == 0)) push(1'b1);
        tick();
        tick();
        chk("frame_end_pulse", FRAME_END, 1'b1);
        chk("frame_end_idle", PIX_READY, 1'b0);
        tick();
        chk("frame_end_clear", FRAME_END, 1'b0);
        chk("frame2_ready", PIX_READY, 1'b1);
        chk("frame1_starts", mon_starts, 576);
        chk("frame1_last", {mon_last_x, mon_last_y}, {5'd23, 5'd23});
        chk("frame1_order", mon_order_err, 0);
        chk("frame1_win", mon_win_err, 0);
        chk("frame1_fe", mon_fe, 1);

        // frame 2 with DONE held high while streaming
        auto_done = 1'b0;
        DONE = 1'b1;
        repeat (100) push(1'b0);
        DONE = 1'b0;
        repeat (16) push(1'b0);
        chk("f2_no_early", mon_starts, 576);
        push(1'b0);
        chk("f2_start", START, 1'b1);
        chk("f2_xy", {X, Y}, 10'd0);
        chk("f2_starts", mon_starts, 577);
        chk("f2_fe", mon_fe, 1);

        // run to window (7,9), then reset while waiting on DONE
        auto_done = 1'b1;
        while (!(tr == 13 && tc == 12)) push(1'b1);
        auto_done = 1'b0;
        DONE = 1'b0;
        chk("rw_start", START, 1'b1);
        chk("rw_xy", {X, Y}, {5'd7, 5'd9});
        tick();
        chk("rw_wait_ready", PIX_READY, 1'b0);
        PIX_VALID = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        PIX_VALID = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        tr = 0;
        tc = 0;
        base = mon_starts;
        auto_done = 1'b1;
        repeat (116) push(1'b0);
        chk("post_rst_no_early", mon_starts, base);
        push(1'b0);
        chk("post_rst_start", START, 1'b1);
        chk("post_rst_xy", {X, Y}, 10'd0);
        chk("post_rst_starts", mon_starts, base + 1);
        chk("final_order", mon_order_err, 0);
        chk("final_win", mon_win_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
